// File: rtl/led_debugger_multi.sv
// Multi-channel LED debugger: per-channel stream FIFOs, STEP/LIVE draining,
// debounced front-panel buttons and a paged, registered LED view of one held word.
module led_debugger_multi #(
  parameter int DATA_WIDTH      = 8,
  parameter int CHANNEL_BITS    = 1,
  parameter int DEPTH_BITS      = 4,
  parameter int LED_WIDTH       = 8,
  parameter int PAGE_BITS       = 1,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [(2**CHANNEL_BITS)*DATA_WIDTH-1:0] in_data,
  input  logic [(2**CHANNEL_BITS)-1:0]            in_valid,
  output logic [(2**CHANNEL_BITS)-1:0]            in_ready,
  input  logic                                    button_next,
  input  logic                                    button_channel,
  input  logic                                    button_page,
  input  logic                                    mode_live,
  output logic [LED_WIDTH-1:0]                    leds,
  output logic [CHANNEL_BITS-1:0]                 channel_sel,
  output logic [PAGE_BITS-1:0]                    page_sel,
  output logic [(2**CHANNEL_BITS)-1:0]            pending,
  output logic [(2**CHANNEL_BITS)-1:0]            overflow
);

  localparam int CHANNELS = 2**CHANNEL_BITS;
  localparam int DEPTH    = 2**DEPTH_BITS;
  localparam int PAGES    = (DATA_WIDTH + LED_WIDTH - 1) / LED_WIDTH;
  localparam int DISP_W   = LED_WIDTH * (2**PAGE_BITS);
  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PAGE_BITS-1:0] PAGE_LAST = PAGE_BITS'(PAGES - 1);

  // Button bit order: [0] next, [1] channel, [2] page
  logic [2:0]              r_btn_meta;
  logic [2:0]              r_btn_sync;
  logic [2:0]              r_db_level;
  logic [2:0]              r_db_prev;
  logic [CNT_W-1:0]        r_db_cnt [3];
  logic [1:0]              r_mode_sync;

  logic [DEPTH_BITS:0]     r_wr_ptr [CHANNELS];
  logic [DEPTH_BITS:0]     r_rd_ptr [CHANNELS];
  logic [DATA_WIDTH-1:0]   r_mem    [CHANNELS][DEPTH];
  logic [DATA_WIDTH-1:0]   r_held   [CHANNELS];
  logic [CHANNEL_BITS-1:0] r_channel_sel;
  logic [PAGE_BITS-1:0]    r_page_sel;
  logic [CHANNELS-1:0]     r_overflow;
  logic [LED_WIDTH-1:0]    r_leds;

  logic [2:0]              w_pulse;
  logic                    w_live;
  logic [CHANNELS-1:0]     w_empty;
  logic [CHANNELS-1:0]     w_full;
  logic [CHANNELS-1:0]     w_push;
  logic [CHANNELS-1:0]     w_pop;
  logic [CHANNELS-1:0]     w_ovf_clr;
  logic [DATA_WIDTH-1:0]   w_held_next [CHANNELS];
  logic [CHANNEL_BITS-1:0] w_channel_next;
  logic [PAGE_BITS-1:0]    w_page_next;
  logic [DISP_W-1:0]       w_disp;
  logic [LED_WIDTH-1:0]    w_leds_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_btn_meta  <= '0;
      r_btn_sync  <= '0;
      r_db_level  <= '0;
      r_db_prev   <= '0;
      r_mode_sync <= '0;
      for (int unsigned i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_btn_meta  <= {button_page, button_channel, button_next};
      r_btn_sync  <= r_btn_meta;
      r_db_prev   <= r_db_level;
      r_mode_sync <= {r_mode_sync[0], mode_live};
      // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_btn_sync[i] != r_db_level[i]) begin
          if (r_db_cnt[i] == CNT_LAST) begin
            r_db_level[i] <= r_btn_sync[i];
            r_db_cnt[i]   <= '0;
          end else begin
            r_db_cnt[i]   <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_pulse = r_db_level & ~r_db_prev;
  assign w_live  = r_mode_sync[1];

  always_comb begin
    w_empty   = '0;
    w_full    = '0;
    w_push    = '0;
    w_pop     = '0;
    w_ovf_clr = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_empty[c]     = (r_wr_ptr[c] == r_rd_ptr[c]);
      w_full[c]      = (r_wr_ptr[c][DEPTH_BITS] != r_rd_ptr[c][DEPTH_BITS]) &&
                       (r_wr_ptr[c][DEPTH_BITS-1:0] == r_rd_ptr[c][DEPTH_BITS-1:0]);
      w_push[c]      = in_valid[c] & ~w_full[c];
      w_pop[c]       = ~w_empty[c] &
                       (w_live | (w_pulse[0] & (r_channel_sel == CHANNEL_BITS'(c))));
      w_ovf_clr[c]   = ~w_live & w_pulse[0] & (r_channel_sel == CHANNEL_BITS'(c)) & w_empty[c];
      w_held_next[c] = w_pop[c] ? r_mem[c][r_rd_ptr[c][DEPTH_BITS-1:0]] : r_held[c];
    end
  end

  // LEDs are registered from next-state values so they track held/select changes at the same edge
  always_comb begin
    w_channel_next = r_channel_sel;
    w_page_next    = r_page_sel;
    if (w_pulse[1]) begin
      w_channel_next = r_channel_sel + 1'b1;
      w_page_next    = '0;
    end else if (w_pulse[2]) begin
      w_page_next    = (r_page_sel == PAGE_LAST) ? '0 : r_page_sel + 1'b1;
    end
    w_disp                   = '0;
    w_disp[DATA_WIDTH-1:0]   = w_held_next[w_channel_next];
    w_leds_next              = w_disp[w_page_next*LED_WIDTH +: LED_WIDTH];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_held[c]   <= '0;
      end
      r_channel_sel <= '0;
      r_page_sel    <= '0;
      r_overflow    <= '0;
      r_leds        <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
        if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
        r_held[c] <= w_held_next[c];
      end
      r_overflow    <= (in_valid & w_full) | (r_overflow & ~w_ovf_clr);
      r_channel_sel <= w_channel_next;
      r_page_sel    <= w_page_next;
      r_leds        <= w_leds_next;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_push[c]) r_mem[c][r_wr_ptr[c][DEPTH_BITS-1:0]] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign in_ready    = ~w_full;
  assign pending     = ~w_empty;
  assign overflow    = r_overflow;
  assign leds        = r_leds;
  assign channel_sel = r_channel_sel;
  assign page_sel    = r_page_sel;

endmodule

// File: tb/tb_led_debugger_multi.sv
// Scoreboard bench for led_debugger_multi: per-channel queues of pushed words,
// popped and compared against the LEDs whenever the design displays a new word.
module tb_led_debugger_multi;

  localparam int DW    = 12;
  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [CH*DW-1:0] in_data = '0;
  logic [CH-1:0]    in_valid = '0;
  logic [CH-1:0]    in_ready;
  logic             button_next = 1'b0;
  logic             button_channel = 1'b0;
  logic             button_page = 1'b0;
  logic             mode_live = 1'b0;
  logic [LW-1:0]    leds;
  logic             channel_sel;
  logic             page_sel;
  logic [CH-1:0]    pending;
  logic [CH-1:0]    overflow;

  led_debugger_multi #(
    .DATA_WIDTH      (DW),
    .CHANNEL_BITS    (1),
    .DEPTH_BITS      (2),
    .LED_WIDTH       (LW),
    .PAGE_BITS       (1),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .button_next    (button_next),
    .button_channel (button_channel),
    .button_page    (button_page),
    .mode_live      (mode_live),
    .leds           (leds),
    .channel_sel    (channel_sel),
    .page_sel       (page_sel),
    .pending        (pending),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] sbq [CH][$];
  logic [DW-1:0] exp_held [CH];
  logic [CH-1:0] exp_ovf = '0;
  int            exp_ch = 0;
  int            exp_page = 0;
  bit            live_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [7:0] disp(input logic [DW-1:0] w, input int pg);
    return 8'((w >> (LW * pg)) & 12'hFF);
  endfunction

  task automatic check_all(input string tag);
    logic [CH-1:0] pend;
    logic [CH-1:0] rdy;
    for (int c = 0; c < CH; c++) begin
      pend[c] = (sbq[c].size() != 0);
      rdy[c]  = (sbq[c].size() < DEPTH);
    end
    check({tag, ".leds"},     32'(leds),        32'(disp(exp_held[exp_ch], exp_page)));
    check({tag, ".chan"},     32'(channel_sel), exp_ch);
    check({tag, ".page"},     32'(page_sel),    exp_page);
    check({tag, ".pending"},  32'(pending),     32'(pend));
    check({tag, ".overflow"}, 32'(overflow),    32'(exp_ovf));
    check({tag, ".in_ready"}, 32'(in_ready),    32'(rdy));
  endtask

  task automatic push_word(input int c, input logic [DW-1:0] d);
    in_data[c*DW +: DW] = d;
    in_valid[c] = 1'b1;
    if (sbq[c].size() < DEPTH) begin
      check("push.in_ready_open", 32'(in_ready[c]), 1);
      sbq[c].push_back(d);
    end else begin
      check("push.in_ready_full", 32'(in_ready[c]), 0);
      exp_ovf[c] = 1'b1;
    end
    tick(1);
    in_valid[c] = 1'b0;
  endtask

  // Pulse appears 6 cycles after raising; state is checked in the pulse cycle and the one after.
  task automatic press(input bit nx, input bit chn, input bit pg, input string tag);
    button_next = nx;
    button_channel = chn;
    button_page = pg;
    tick(6);
    check_all({tag, ".pre"});
    if (nx && !live_m) begin
      if (sbq[exp_ch].size() > 0) exp_held[exp_ch] = sbq[exp_ch].pop_front();
      else exp_ovf[exp_ch] = 1'b0;
    end
    if (chn) begin
      exp_ch = (exp_ch + 1) % CH;
      exp_page = 0;
    end else if (pg) begin
      exp_page = (exp_page + 1) % 2;
    end
    button_next = 1'b0;
    button_channel = 1'b0;
    button_page = 1'b0;
    tick(1);
    check_all({tag, ".post"});
    tick(9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < CH; c++) exp_held[c] = '0;
    tick(2);
    check_all("reset");
    reset = 1'b1;
    tick(2);

    // STEP mode with paging
    push_word(0, 12'hABC);
    push_word(0, 12'h123);
    check_all("t1.fill");
    press(1, 0, 0, "t1.next1");
    press(0, 0, 1, "t1.page");
    press(1, 0, 0, "t1.next2");

    // 3-cycle glitch must not pop
    push_word(0, 12'h456);
    button_next = 1'b1;
    tick(3);
    button_next = 1'b0;
    tick(12);
    check_all("t2.glitch");
    press(1, 0, 0, "t2.next");

    // Channel switching and simultaneous presses
    push_word(1, 12'h055);
    press(0, 1, 0, "t4.sel1");
    press(1, 0, 0, "t4.pop1");
    press(0, 1, 0, "t4.sel0");
    push_word(0, 12'h0AA);
    press(1, 0, 0, "t4.pop0");
    press(0, 1, 0, "t4.switch");
    push_word(1, 12'h077);
    press(1, 1, 0, "t4.next_chan");
    press(0, 1, 0, "t4.sel1b");
    press(0, 0, 1, "t4.page1");
    press(0, 1, 1, "t4.chan_page");

    // Full FIFO and overflow on ch1
    for (int k = 1; k <= 5; k++) push_word(1, 12'(12'h100 + k));
    check_all("t3.full");
    press(0, 1, 0, "t3.sel1");
    press(1, 0, 0, "t3.pop");

    // LIVE mode
    mode_live = 1'b1;
    live_m = 1'b1;
    tick(6);
    while (sbq[1].size() > 0) exp_held[1] = sbq[1].pop_front();
    check_all("t5.enter");
    press(0, 1, 0, "t5.sel0");
    for (int k = 1; k <= 10; k++) begin
      push_word(0, 12'(k));
      if (k > 1) begin
        exp_held[0] = sbq[0].pop_front();
        check("t5.live_leds", 32'(leds), 32'(disp(exp_held[0], exp_page)));
      end
    end
    tick(1);
    exp_held[0] = sbq[0].pop_front();
    check_all("t5.done");
    press(1, 0, 0, "t5.next_ignored");
    mode_live = 1'b0;
    live_m = 1'b0;
    tick(4);

    // Asynchronous reset mid-stream, then overflow clear on an empty next
    push_word(0, 12'h0C1);
    push_word(0, 12'h0C2);
    check_all("t6.pre");
    in_data[0 +: DW] = 12'h0C3;
    in_valid[0] = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("t6.async_leds",     32'(leds),     0);
    check("t6.async_pending",  32'(pending),  0);
    check("t6.async_overflow", 32'(overflow), 0);
    for (int c = 0; c < CH; c++) begin
      sbq[c].delete();
      exp_held[c] = '0;
    end
    exp_ovf = '0;
    exp_ch = 0;
    exp_page = 0;
    in_valid = '0;
    tick(1);
    check_all("t6.reset");
    reset = 1'b1;
    tick(2);
    for (int k = 1; k <= 5; k++) push_word(0, 12'(12'h200 + k));
    check_all("t6.fill");
    for (int k = 1; k <= 4; k++) press(1, 0, 0, "t6.drain");
    press(1, 0, 0, "t6.clear");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
